// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed 7-segment display blocks.
// Segment encodings are active low, bit order {g,f,e,d,c,b,a}.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;

  // Scan scheduler state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // Decimal digit patterns; element n holds the pattern for digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Non-decimal nibbles (10-15) show a dash.
module bcd_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_c
);

  // Table lookup for 0-9, dash otherwise.
  always_comb begin
    seg_c = SEG_DASH;
    if (bcd < 4'd10) begin
      seg_c = SEG_TABLE[bcd];
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scan scheduler for the 4-digit multiplexed 7-segment stopwatch display.
// Each digit slot is REFRESH_DIV cycles: BLANK_CYC cycles with all anodes off,
// then the digit's anode driven. digits_in is snapshotted once per frame.
// Optional feature: define DISP_DIM_EN to add a brightness[2:0] input that
// trims the lit portion of each drive phase.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 16,
  parameter int unsigned DP_DIGIT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        blank_lz,
  input  logic [15:0] digits_in,
`ifdef DISP_DIM_EN
  input  logic [2:0]  brightness,
`endif
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int unsigned CNT_W     = $clog2(REFRESH_DIV);
  localparam int unsigned DRIVE_CYC = REFRESH_DIV - BLANK_CYC;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Parameter sanity: the drive phase must be non-empty.
  if (REFRESH_DIV <= BLANK_CYC || BLANK_CYC == 0) begin : g_bad_params
    $error("display_scan_ctrl: need REFRESH_DIV > BLANK_CYC > 0");
  end

  scan_state_e      state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      snap_q, snap_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             fs_q, fs_d;
  logic             load;
  logic             hide;
  logic             lit;
  logic [3:0]       nibble;
  logic [6:0]       dec_seg;
`ifdef DISP_DIM_EN
  logic [2:0]       bright_q, bright_d;
  logic [31:0]      drive_cnt;
`endif

  // Next-state: slot timing, digit rotation and per-frame snapshot.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    fs_d    = 1'b0;
    load    = 1'b0;
`ifdef DISP_DIM_EN
    bright_d = bright_q;
`endif
    if (!en) begin
      state_d = ST_IDLE;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          idx_d   = 2'd0;
          cnt_d   = '0;
          snap_d  = digits_in;
          fs_d    = 1'b1;
          load    = 1'b1;
`ifdef DISP_DIM_EN
          bright_d = brightness;
`endif
        end
        ST_BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            load    = 1'b1;
            if (idx_q == 2'd3) begin
              snap_d = digits_in;
              fs_d   = 1'b1;
`ifdef DISP_DIM_EN
              bright_d = brightness;
`endif
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign nibble = snap_d[{idx_d, 2'b00} +: 4];

  bcd_to_seg u_dec (
    .bcd   (nibble),
    .seg_c (dec_seg)
  );

  // Output shaping: segment/dp reload on slot entry, anode drive, blanking.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = seg_q;
    dp_d  = dp_q;
    lit   = 1'b1;
    hide  = blank_lz && (32'(idx_d) > DP_DIGIT);
    for (int j = 0; j < int'(NUM_DIGITS); j++) begin
      if (j >= int'(idx_d) && snap_d[j*4 +: 4] != 4'd0) begin
        hide = 1'b0;
      end
    end
`ifdef DISP_DIM_EN
    drive_cnt = 32'(cnt_d) - BLANK_CYC;
    lit = (drive_cnt * 32'd8) < ((32'(bright_q) + 32'd1) * DRIVE_CYC);
`endif
    if (state_d == ST_IDLE) begin
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end else if (load) begin
      seg_d = hide ? SEG_OFF : dec_seg;
      dp_d  = !(32'(idx_d) == DP_DIGIT);
    end
    if (state_d == ST_DRIVE && lit) begin
      an_d = ~(4'b0001 << idx_d);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      snap_q  <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      fs_q    <= 1'b0;
`ifdef DISP_DIM_EN
      bright_q <= 3'd7;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fs_q    <= fs_d;
`ifdef DISP_DIM_EN
      bright_q <= bright_d;
`endif
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (REFRESH_DIV=8, BLANK_CYC=2, DP_DIGIT=2).
// Build with +define+DISP_DIM_EN to exercise the brightness port.
module tb_display_scan_ctrl;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SX = 7'h7F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        blank_lz;
  logic [15:0] digits_in;
  logic [2:0]  brightness;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int errors = 0;
  int checks = 0;
  int bright = 7;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .REFRESH_DIV (8),
    .BLANK_CYC   (2),
    .DP_DIGIT    (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .blank_lz    (blank_lz),
    .digits_in   (digits_in),
`ifdef DISP_DIM_EN
    .brightness  (brightness),
`endif
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  typedef struct {
    logic [15:0]     digits;
    logic            lz;
    logic            restart;
    int              chg_at;
    logic [15:0]     chg_val;
    logic [3:0][6:0] segs;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_an"},  16'(an),          16'hF);
    chk({name, "_seg"}, 16'(seg),         16'(SX));
    chk({name, "_dp"},  16'(dp),          16'd1);
    chk({name, "_fs"},  16'(frame_start), 16'd0);
  endtask

  // Expected outputs for cycle c of a frame (c=0 is the cycle with frame_start).
  task automatic check_cycle(input int c, input logic [3:0][6:0] segs);
    int slot, ph;
    logic [3:0] exp_an;
    slot = (c % 32) / 8;
    ph   = c % 8;
    exp_an = 4'hF;
    if (ph >= 2 && (ph - 2) * 8 < (bright + 1) * 6) exp_an = ~(4'b0001 << slot);
    chk("an",  16'(an),          16'(exp_an));
    chk("seg", 16'(seg),         16'(segs[slot]));
    chk("dp",  16'(dp),          (slot == 2) ? 16'd0 : 16'd1);
    chk("fs",  16'(frame_start), (c % 32 == 0) ? 16'd1 : 16'd0);
  endtask

  // Drop en for one cycle, check dark outputs, then re-enable with new inputs.
  task automatic restart(input logic [15:0] d, input logic lz);
    en = 1'b0;
    @(negedge clk);
    chk_idle("idle");
    digits_in = d;
    blank_lz  = lz;
    en        = 1'b1;
  endtask

  initial begin
    vecs[0] = '{16'h1234, 1'b0, 1'b0, -1, 16'h0000, {S1, S2, S3, S4}};
    vecs[1] = '{16'h1234, 1'b0, 1'b0, 10, 16'h5678, {S1, S2, S3, S4}};
    vecs[2] = '{16'h5678, 1'b0, 1'b0, -1, 16'h0000, {S5, S6, S7, S8}};
    vecs[3] = '{16'h00A5, 1'b1, 1'b1, -1, 16'h0000, {SX, S0, SD, S5}};
    vecs[4] = '{16'h00A5, 1'b0, 1'b1, -1, 16'h0000, {S0, S0, SD, S5}};
    vecs[5] = '{16'h0000, 1'b1, 1'b1, -1, 16'h0000, {SX, S0, S0, S0}};
    vecs[6] = '{16'h0905, 1'b1, 1'b1, -1, 16'h0000, {SX, S9, S0, S5}};
    vecs[7] = '{16'hF000, 1'b1, 1'b1, -1, 16'h0000, {SD, S0, S0, S0}};

    rst_n = 1'b0;
    en = 1'b1;
    blank_lz = 1'b0;
    digits_in = 16'h1234;
    brightness = 3'd7;

    // Reset held with en=1: outputs stay dark.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk_idle("reset");
    end
    rst_n = 1'b1;

    // Vector table: full frames, mid-frame change, blanking patterns.
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].restart) restart(vecs[v].digits, vecs[v].lz);
      else begin
        digits_in = vecs[v].digits;
        blank_lz  = vecs[v].lz;
      end
      for (int c = 0; c < 32; c++) begin
        @(negedge clk);
        check_cycle(c, vecs[v].segs);
        if (c == vecs[v].chg_at) digits_in = vecs[v].chg_val;
      end
    end

    // en dropped mid-DRIVE: dark next cycle, then clean restart at digit 0.
    restart(16'h1234, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_cycle(c, {S1, S2, S3, S4});
    end
    en = 1'b0;
    @(negedge clk);
    chk_idle("en_off");
    en = 1'b1;
    for (int c = 0; c < 33; c++) begin
      @(negedge clk);
      check_cycle(c, {S1, S2, S3, S4});
    end

`ifdef DISP_DIM_EN
    // Brightness 3: anode lit for 3 of 6 drive cycles.
    en = 1'b0;
    brightness = 3'd3;
    @(negedge clk);
    chk_idle("dim_idle");
    en = 1'b1;
    bright = 3;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      check_cycle(c, {S1, S2, S3, S4});
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
